// File: rtl/onehot_idx_reg.sv
// Registered one-hot to binary index encoder: lowest set bit wins, o_multi flags
// any input carrying more than one set bit. All outputs are flopped (1-cycle latency).
module onehot_idx_reg #(
    parameter int WIDTH = 16,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_onehot,
    output logic [IDX_W-1:0] o_index,
    output logic             o_valid,
    output logic             o_multi
);

    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] lowest;
    logic [IDX_W-1:0] index_c;
    logic             valid_c;
    logic             multi_c;

    // dec = x-1; x & ~dec isolates the lowest set bit, x & dec keeps the rest.
    assign dec     = i_onehot - WIDTH'(1);
    assign lowest  = i_onehot & ~dec;
    assign valid_c = |i_onehot;
    assign multi_c = |(i_onehot & dec);

    // Each index bit is an OR over the isolated positions whose number has that bit set.
    // Only WIDTH codes can ever appear, so unused index codes are unreachable.
    always_comb begin
        // NOTE: default first so every path assigns index_c and no latch is inferred.
        index_c = '0;
        for (int b = 0; b < WIDTH; b++) begin
            index_c = index_c | ({IDX_W{lowest[b]}} & IDX_W'(b));
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments for flops so all three outputs update together.
        if (i_rst) begin
            o_index <= '0;
            o_valid <= 1'b0;
            o_multi <= 1'b0;
        end else begin
            o_index <= index_c;
            o_valid <= valid_c;
            o_multi <= multi_c;
        end
    end

endmodule

// File: tb/tb_onehot_idx_reg.sv
// Directed bench for onehot_idx_reg: WIDTH=16 and WIDTH=9 instances share clock and reset.
module tb_onehot_idx_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] onehot16;
    logic [8:0]  onehot9;
    logic [3:0]  index16;
    logic [3:0]  index9;
    logic        valid16, multi16, valid9, multi9;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    onehot_idx_reg #(.WIDTH(16)) dut16 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_onehot (onehot16),
        .o_index  (index16),
        .o_valid  (valid16),
        .o_multi  (multi16)
    );

    onehot_idx_reg #(.WIDTH(9)) dut9 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_onehot (onehot9),
        .o_index  (index9),
        .o_valid  (valid9),
        .o_multi  (multi9)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check16(input string tag, input int idx, input bit val, input bit mul);
        check({tag, ".index"}, 32'(index16), 32'(idx));
        check({tag, ".valid"}, 32'(valid16), 32'(val));
        check({tag, ".multi"}, 32'(multi16), 32'(mul));
    endtask

    typedef struct {
        logic [15:0] vec;
        int          idx;
        bit          val;
        bit          mul;
    } vec_t;

    vec_t table16 [8] = '{
        '{16'h0280, 7,  1'b1, 1'b1},
        '{16'h8000, 15, 1'b1, 1'b0},
        '{16'hFFFF, 0,  1'b1, 1'b1},
        '{16'h0004, 2,  1'b1, 1'b0},
        '{16'h0010, 4,  1'b1, 1'b0},
        '{16'h0000, 0,  1'b0, 1'b0},
        '{16'h0040, 6,  1'b1, 1'b0},
        '{16'hA000, 13, 1'b1, 1'b1}
    };

    initial begin
        rst      = 1'b1;
        onehot16 = 16'hFFFF;
        onehot9  = 9'h1FF;
        for (int c = 0; c < 3; c++) begin
            tick();
            check16("reset16", 0, 1'b0, 1'b0);
            check("reset9.index", 32'(index9), 32'd0);
            check("reset9.valid", 32'(valid9), 32'd0);
            check("reset9.multi", 32'(multi9), 32'd0);
        end

        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            onehot16 = 16'(1) << (i % 16);
            onehot9  = 9'(1) << (i % 9);
            tick();
            check16("walk16", i % 16, 1'b1, 1'b0);
            check("walk9.index", 32'(index9), 32'(i % 9));
            check("walk9.valid", 32'(valid9), 32'd1);
            check("walk9.multi", 32'(multi9), 32'd0);
        end

        onehot9 = 9'h000;
        tick();
        check("zero9.index", 32'(index9), 32'd0);
        check("zero9.valid", 32'(valid9), 32'd0);
        check("zero9.multi", 32'(multi9), 32'd0);

        onehot9 = 9'h180;
        tick();
        check("multi9.index", 32'(index9), 32'd7);
        check("multi9.multi", 32'(multi9), 32'd1);

        for (int t = 0; t < 8; t++) begin
            onehot16 = table16[t].vec;
            tick();
            check16($sformatf("vec16[%0d]", t), table16[t].idx, table16[t].val, table16[t].mul);
        end

        // Outputs are 13/1/1 from the last vector; reset must clear them despite 0x0100.
        rst      = 1'b1;
        onehot16 = 16'h0100;
        tick();
        check16("midrst", 0, 1'b0, 1'b0);
        tick();
        check16("midrst_hold", 0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check16("post_rst", 8, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
